phase_ctrl: RTL

PHASE_CTRL -- requirements
Module: phase_ctrl

---
 rtl/phase_ctrl_if.sv | 26 ++
 rtl/phase_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/phase_ctrl_if.sv
// Control/handshake bundle between the phase controller and its datapath/memory side.
// master drives the commands, instruction word and memory ack; slave is the controller.
interface phase_ctrl_if;
  logic        run;
  logic        step;
  logic        stop;
  logic [31:0] ir;
  logic        mem_ack;
  logic [4:0]  phase;
  logic        mem_req;
  logic        ir_we;
  logic        pc_we;
  logic        halted;
  logic        timeout;
  logic [15:0] instr_count;

  modport master (
    output run, step, stop, ir, mem_ack,
    input  phase, mem_req, ir_we, pc_we, halted, timeout, instr_count
  );

  modport slave (
    input  run, step, stop, ir, mem_ack,
    output phase, mem_req, ir_we, pc_we, halted, timeout, instr_count
  );
endinterface

// File: rtl/phase_ctrl.sv
// Instruction phase sequencer: IDLE -> F -> R -> X -> (M) -> W with run/step/stop
// control, bounded memory waits (timeout halts) and a retired-instruction counter.
module phase_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  phase_ctrl_if.slave bus
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_F, S_R, S_X, S_M, S_W, S_HALT
  } state_t;

  state_t        state, nxt;
  logic          step_mode;
  logic [WW-1:0] wcnt;
  logic [15:0]   instr_cnt;
  logic [4:0]    phase_q;
  logic          mem_req_q, pc_we_q, halted_q, timeout_q;
  logic          waiting, expired;
  logic          unused_ir;

  assign unused_ir = ^bus.ir[26:0];

  // wcnt holds completed wait cycles; an ack in the final allowed cycle still wins
  assign waiting = (state == S_F || state == S_M) && !bus.mem_ack;
  assign expired = waiting && (wcnt == LAST);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.run || bus.step) nxt = S_F;
      S_F: begin
        if (bus.mem_ack)  nxt = S_R;
        else if (expired) nxt = S_HALT;
      end
      S_R: nxt = S_X;
      S_X: nxt = (bus.ir[31:28] == 4'b0100) ? S_M : S_W;
      S_M: begin
        if (bus.mem_ack)  nxt = S_W;
        else if (expired) nxt = S_HALT;
      end
      S_W: begin
        if (bus.ir[31:27] == 5'b11111)   nxt = S_HALT;
        else if (step_mode || bus.stop) nxt = S_IDLE;
        else                            nxt = S_F;
      end
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
      wcnt      <= '0;
      instr_cnt <= '0;
      phase_q   <= '0;
      mem_req_q <= 1'b0;
      pc_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && bus.run)       step_mode <= 1'b0;
      else if (state == S_IDLE && bus.step) step_mode <= 1'b1;
      if (nxt != state)  wcnt <= '0;
      else if (waiting)  wcnt <= wcnt + 1'b1;
      if (expired)       timeout_q <= 1'b1;
      if (state == S_W)  instr_cnt <= instr_cnt + 16'd1;
      case (nxt)
        S_F:     phase_q <= 5'b00001;
        S_R:     phase_q <= 5'b00010;
        S_X:     phase_q <= 5'b00100;
        S_M:     phase_q <= 5'b01000;
        S_W:     phase_q <= 5'b10000;
        default: phase_q <= 5'b00000;
      endcase
      mem_req_q <= (nxt == S_F) || (nxt == S_M);
      pc_we_q   <= (nxt == S_W);
      halted_q  <= (nxt == S_HALT);
    end
  end

  assign bus.phase       = phase_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.ir_we       = (state == S_F) && bus.mem_ack;
  assign bus.pc_we       = pc_we_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.instr_count = instr_cnt;

endmodule
